line_follow_ctrl: RTL

LINE_FOLLOW_CTRL -- requirements
Module: line_follow_ctrl

---
 rtl/line_follow_pkg.sv | 24 ++
 rtl/input_debounce.sv | 42 ++++
 rtl/line_follow_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/line_follow_pkg.sv
// Shared types for the line-following robot controller:
// FSM state codes (also the debug encoding) and motor command words.
package line_follow_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FOLLOW    = 3'd1,
        ST_JUNCTION  = 3'd2,
        ST_UTURN_OFF = 3'd3,
        ST_UTURN_ON  = 3'd4,
        ST_LOST      = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    localparam logic [3:0] CMD_FWD    = 4'b0110;
    localparam logic [3:0] CMD_SPIN_L = 4'b1010;
    localparam logic [3:0] CMD_SPIN_R = 4'b0101;
    localparam logic [3:0] CMD_STOP   = 4'b0000;

    function automatic logic [1:0] cmd_en(input logic [3:0] cmd);
        return (cmd == CMD_STOP) ? 2'b00 : 2'b11;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a per-bit stability filter:
// a bit's output changes only after DB_CYC consecutive differing samples.
module input_debounce #(
    parameter int                WIDTH   = 5,
    parameter int                DB_CYC  = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] clean
);

    localparam int CW = $clog2(DB_CYC + 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CW-1:0]    cnt [WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= RST_VAL;
            s2    <= RST_VAL;
            clean <= RST_VAL;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == clean[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DB_CYC - 1)) begin
                    clean[i] <= s2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following motor controller: debounced sensors drive a
// follow / junction / U-turn / lost FSM with registered motor commands.
module line_follow_ctrl
    import line_follow_pkg::*;
#(
    parameter int N_SENS   = 3,
    parameter int DB_CYC   = 4,
    parameter int LOST_CYC = 1000,
    parameter int TURN_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [N_SENS-1:0] induct,
    input  logic              proxim,
    input  logic              red,
    output logic [3:0]        motor_in,
    output logic [1:0]        motor_en,
    output logic [2:0]        state_o,
    output logic              fault
);

    localparam int C  = (N_SENS - 1) / 2;
    localparam int SW = $clog2(N_SENS + 1);
    localparam int LW = $clog2(LOST_CYC + 1);
    localparam int TW = $clog2(TURN_CYC + 1);

    logic [N_SENS+1:0] db;
    logic [N_SENS-1:0] on;
    logic              prx, rd, red_q;
    logic              all_on, all_off, ctr_on;
    logic              red_rise, red_fall, t_done, l_done;
    logic [SW-1:0]     l_cnt, r_cnt;
    logic [LW-1:0]     lcnt;
    logic [TW-1:0]     tcnt;
    logic [3:0]        last_cmd, steer, spin, cmd_next;
    logic              td, td_next, cone, cone_next;
    state_t            state, next;

    input_debounce #(
        .WIDTH  (N_SENS + 2),
        .DB_CYC (DB_CYC),
        .RST_VAL({{N_SENS{1'b1}}, 2'b00})
    ) u_db (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  ({induct, proxim, red}),
        .clean(db)
    );

    // Sensors are active-low; work with "on line" polarity internally.
    assign on       = ~db[N_SENS+1:2];
    assign prx      = db[1];
    assign rd       = db[0];
    assign all_on   = &on;
    assign all_off  = ~|on;
    assign ctr_on   = on[C];
    assign red_rise = rd & ~red_q;
    assign red_fall = ~rd & red_q;
    assign t_done   = (tcnt >= TW'(TURN_CYC - 1));
    assign l_done   = (lcnt >= LW'(LOST_CYC - 1));
    assign td_next  = td ^ red_rise;
    assign spin     = td_next ? CMD_SPIN_R : CMD_SPIN_L;
    assign state_o  = state;

    always_comb begin
        l_cnt = '0;
        r_cnt = '0;
        for (int i = 0; i < N_SENS; i++) begin
            if (i > C) l_cnt = l_cnt + SW'(on[i]);
            else if (i < C) r_cnt = r_cnt + SW'(on[i]);
        end
        steer = last_cmd;
        if (l_cnt > r_cnt) steer = CMD_SPIN_L;
        else if (r_cnt > l_cnt) steer = CMD_SPIN_R;
        else if (ctr_on) steer = CMD_FWD;
    end

    always_comb begin
        next      = state;
        cone_next = cone;
        if (red_fall) cone_next = 1'b0;
        unique case (state)
            ST_IDLE:      if (run) next = ST_FOLLOW;
            ST_FOLLOW: begin
                if (prx) begin
                    next      = ST_UTURN_OFF;
                    cone_next = 1'b1;
                end else if (red_rise && cone) next = ST_UTURN_OFF;
                else if (all_on) next = ST_JUNCTION;
                else if (all_off) next = ST_LOST;
            end
            ST_JUNCTION: begin
                if (red_rise && cone) next = ST_UTURN_OFF;
                else if (!all_on) next = ST_FOLLOW;
            end
            ST_UTURN_OFF: begin
                if (t_done) next = ST_FAULT;
                else if (all_off) next = ST_UTURN_ON;
            end
            ST_UTURN_ON: begin
                if (t_done) next = ST_FAULT;
                else if (ctr_on) next = ST_FOLLOW;
            end
            ST_LOST: begin
                if (red_rise && cone) next = ST_UTURN_OFF;
                else if (!all_off) next = ST_FOLLOW;
                else if (l_done) next = ST_FAULT;
            end
            ST_FAULT:     next = ST_FAULT;
            default:      next = ST_IDLE;
        endcase
        if (!run && state != ST_FAULT) begin
            next      = ST_IDLE;
            cone_next = cone & ~red_fall;
        end
    end

    // Command follows the state being entered so it lands with it.
    always_comb begin
        cmd_next = CMD_STOP;
        unique case (next)
            ST_FOLLOW:    cmd_next = steer;
            ST_JUNCTION,
            ST_UTURN_OFF,
            ST_UTURN_ON:  cmd_next = spin;
            ST_LOST:      cmd_next = last_cmd;
            default:      cmd_next = CMD_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            motor_in <= CMD_STOP;
            motor_en <= 2'b00;
            fault    <= 1'b0;
            td       <= 1'b0;
            cone     <= 1'b0;
            red_q    <= 1'b0;
            last_cmd <= CMD_FWD;
            lcnt     <= '0;
            tcnt     <= '0;
        end else begin
            state    <= next;
            motor_in <= cmd_next;
            motor_en <= cmd_en(cmd_next);
            fault    <= fault | (next == ST_FAULT);
            td       <= td_next;
            cone     <= cone_next;
            red_q    <= rd;
            if (cmd_next != CMD_STOP) last_cmd <= cmd_next;
            if (state != ST_LOST) lcnt <= '0;
            else if (lcnt != LW'(LOST_CYC)) lcnt <= lcnt + 1'b1;
            if (next == ST_UTURN_OFF && state != ST_UTURN_OFF) tcnt <= '0;
            else if ((state == ST_UTURN_OFF || state == ST_UTURN_ON)
                     && tcnt != TW'(TURN_CYC)) tcnt <= tcnt + 1'b1;
        end
    end

endmodule
